// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB completer between two internal requesters.
// Round-robin arbitration, SETUP/ACCESS sequencing, PREADY wait states and a
// programmable PREADY timeout. Every transfer ends with a one-cycle done/err
// pulse to its owner, with read data on rsp_rdata.
module apb_master_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NBYTES         = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req0,
    input  logic                  wr0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [NBYTES-1:0]     strb0,
    input  logic                  req1,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [NBYTES-1:0]     strb1,
    output logic                  done0,
    output logic                  err0,
    output logic                  done1,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [NBYTES-1:0]     PSTRB,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t          state_r;
    logic            last_grant_r;   // requester granted most recently
    logic            owner_r;        // requester owning the transfer in flight
    logic [CW-1:0]   wait_cnt_r;     // ACCESS cycles spent with PREADY low

    logic                  any_req_s;
    logic                  grant_s;
    logic                  timeout_hit_s;
    logic                  sel_wr_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic [NBYTES-1:0]     sel_strb_s;

    // Winner selection (lone requester, else the one not granted last) and its payload.
    always_comb begin
        any_req_s = req0 | req1;
        grant_s   = 1'b0;
        if (req0 && req1) begin
            grant_s = ~last_grant_r;
        end else if (req1) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        sel_wr_s    = grant_s ? wr1    : wr0;
        sel_addr_s  = grant_s ? addr1  : addr0;
        sel_wdata_s = grant_s ? wdata1 : wdata0;
        sel_strb_s  = grant_s ? strb1  : strb0;
    end

    // Timeout fires on the last permitted ACCESS cycle; disabled when TIMEOUT_CYCLES is 0.
    always_comb begin
        timeout_hit_s = 1'b0;
        if (TIMEOUT_CYCLES != 0) begin
            timeout_hit_s = (wait_cnt_r == CW'(TIMEOUT_CYCLES - 1));
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Transfer sequencer: arbitration, APB phases and the registered response pulse.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            wait_cnt_r   <= {CW{1'b0}};
            done0        <= 1'b0;
            err0         <= 1'b0;
            done1        <= 1'b0;
            err1         <= 1'b0;
            rsp_rdata    <= {DATA_WIDTH{1'b0}};
            PSELx        <= 1'b0;
            PENABLE      <= 1'b0;
            PADDR        <= {ADDR_WIDTH{1'b0}};
            PWRITE       <= 1'b0;
            PSTRB        <= {NBYTES{1'b0}};
            PWDATA       <= {DATA_WIDTH{1'b0}};
        end else begin
            done0 <= 1'b0;
            err0  <= 1'b0;
            done1 <= 1'b0;
            err1  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        owner_r      <= grant_s;
                        last_grant_r <= grant_s;
                        wait_cnt_r   <= {CW{1'b0}};
                        PADDR        <= sel_addr_s;
                        PWRITE       <= sel_wr_s;
                        PWDATA       <= sel_wdata_s;
                        PSTRB        <= sel_wr_s ? sel_strb_s : {NBYTES{1'b0}};
                        PSELx        <= 1'b1;
                        PENABLE      <= 1'b0;
                        state_r      <= ST_SETUP;
                    end else begin
                        PSELx   <= 1'b0;
                        PENABLE <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state_r <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata <= PWRITE ? {DATA_WIDTH{1'b0}} : PRDATA;
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        done0     <= ~owner_r;
                        done1     <= owner_r;
                        state_r   <= ST_RESP;
                    end else if (timeout_hit_s) begin
                        rsp_rdata <= {DATA_WIDTH{1'b0}};
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        done0     <= ~owner_r;
                        err0      <= ~owner_r;
                        done1     <= owner_r;
                        err1      <= owner_r;
                        state_r   <= ST_RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CW'(1);
                    end
                end
                ST_RESP: begin
                    // Requests are ignored here; a still-high req is a new transfer in IDLE.
                    rsp_rdata <= {DATA_WIDTH{1'b0}};
                    state_r   <= ST_IDLE;
                end
                default: begin
                    PSELx   <= 1'b0;
                    PENABLE <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: a transaction-level model
// predicts the APB and response outputs every cycle, and directed scenarios
// pin hand-computed values.
module tb_apb_master_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NB = 4;
    localparam int TMO = 16;

    logic          PCLK;
    logic          PRESETn;
    logic          req0, wr0, req1, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [NB-1:0] strb0, strb1;
    logic          done0, err0, done1, err1;
    logic [DW-1:0] rsp_rdata;
    logic          PSELx, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [NB-1:0] PSTRB;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NBYTES(NB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .strb0(strb0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .strb1(strb1),
        .done0(done0), .err0(err0), .done1(done1), .err1(err1),
        .rsp_rdata(rsp_rdata),
        .PSELx(PSELx), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic          e_psel, e_pen, e_wr, e_done0, e_done1, e_err0, e_err1;
    logic [AW-1:0] e_addr;
    logic [NB-1:0] e_strb;
    logic [DW-1:0] e_wdata, e_rdata;
    int            m_last, m_owner, m_acc;
    bit            m_busy, m_resp;

    task automatic model_clear();
        e_psel = 1'b0; e_pen = 1'b0; e_wr = 1'b0;
        e_done0 = 1'b0; e_done1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
        e_addr = '0; e_strb = '0; e_wdata = '0; e_rdata = '0;
        m_last = 1; m_owner = 0; m_acc = 0; m_busy = 1'b0; m_resp = 1'b0;
    endtask

    task automatic model_finish(input bit aborted);
        m_busy = 1'b0; m_resp = 1'b1;
        e_psel = 1'b0; e_pen = 1'b0;
        if (m_owner == 0) begin e_done0 = 1'b1; e_err0 = aborted; end
        else              begin e_done1 = 1'b1; e_err1 = aborted; end
        e_rdata = (aborted || e_wr) ? '0 : PRDATA;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge PCLK or negedge PRESETn);
            if (!PRESETn) begin
                model_clear();
            end else if (m_resp) begin
                // response cycle ends; any request seen now is ignored
                e_done0 = 1'b0; e_done1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
                m_resp = 1'b0;
            end else if (m_busy) begin
                if (!e_pen) begin
                    e_pen = 1'b1;
                    m_acc = 0;
                end else begin
                    m_acc++;
                    if (PREADY) model_finish(1'b0);
                    else if (TMO != 0 && m_acc == TMO) model_finish(1'b1);
                end
            end else if (req0 || req1) begin
                if (req0 && req1) m_owner = (m_last == 0) ? 1 : 0;
                else              m_owner = req0 ? 0 : 1;
                m_last  = m_owner;
                m_busy  = 1'b1;
                e_psel  = 1'b1;
                e_pen   = 1'b0;
                e_wr    = (m_owner == 0) ? wr0 : wr1;
                e_addr  = (m_owner == 0) ? addr0 : addr1;
                e_wdata = (m_owner == 0) ? wdata0 : wdata1;
                e_strb  = e_wr ? ((m_owner == 0) ? strb0 : strb1) : '0;
            end
        end
    end

    // Per-cycle comparison of DUT against the model.
    initial begin
        forever begin
            @(negedge PCLK);
            chk("psel", PSELx, e_psel);
            chk("penable", PENABLE, e_pen);
            chk("done0", done0, e_done0);
            chk("done1", done1, e_done1);
            chk("err0", err0, e_err0);
            chk("err1", err1, e_err1);
            chk("done_excl", done0 & done1, 1'b0);
            if (e_psel) begin
                chk("paddr", PADDR, e_addr);
                chk("pwrite", PWRITE, e_wr);
                chk("pstrb", PSTRB, e_strb);
                chk("pwdata", PWDATA, e_wdata);
            end
            if (e_done0 || e_done1) chk("rsp_rdata", rsp_rdata, e_rdata);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(input int budget, output int which, output int cyc, output int pen);
        which = -1; cyc = 0; pen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge PCLK);
            cyc++;
            if (PENABLE) pen++;
            if (done0) begin which = 0; break; end
            if (done1) begin which = 1; break; end
        end
        if (which < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: no done within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    int which, cyc, pen;

    initial begin
        PRESETn = 1'b0;
        req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0; strb0 = '0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0; strb1 = '0;
        PRDATA = '0; PREADY = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_psel", PSELx, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_done0", done0, 1'b0);
        chk("rst_done1", done1, 1'b0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Lone write from requester 0
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF; strb0 = 4'hF;
        PREADY = 1'b1;
        @(negedge PCLK);
        chk("t1_setup_psel", PSELx, 1'b1);
        chk("t1_setup_pen", PENABLE, 1'b0);
        chk("t1_paddr", PADDR, 32'h10);
        chk("t1_pstrb", PSTRB, 4'hF);
        @(negedge PCLK);
        chk("t1_access_pen", PENABLE, 1'b1);
        chk("t1_pwdata", PWDATA, 32'hDEADBEEF);
        @(negedge PCLK);
        chk("t1_done0", done0, 1'b1);
        chk("t1_err0", err0, 1'b0);
        req0 = 1'b0;
        @(negedge PCLK);
        chk("t1_done_pulse", done0, 1'b0);

        // Read from requester 1 with two wait states
        req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h10; strb1 = 4'hF; wdata1 = 32'h1234;
        PREADY = 1'b0; PRDATA = 32'hDEADBEEF;
        @(negedge PCLK);
        chk("t2_setup_pstrb", PSTRB, 4'h0);
        chk("t2_setup_pwrite", PWRITE, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            chk("t2_access_pen", PENABLE, 1'b1);
            chk("t2_pstrb", PSTRB, 4'h0);
        end
        PREADY = 1'b1;
        @(negedge PCLK);
        chk("t2_done1", done1, 1'b1);
        chk("t2_rdata", rsp_rdata, 32'hDEADBEEF);
        req1 = 1'b0;
        @(negedge PCLK);

        // Continuous contention from reset: grants alternate 0,1,0,1
        do_reset();
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h100; wdata0 = 32'hA0; strb0 = 4'h3;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h200;
        PREADY = 1'b1; PRDATA = 32'hCAFE0001;
        for (int k = 0; k < 4; k++) begin
            wait_done(12, which, cyc, pen);
            chk("t3_order", which, k % 2);
            chk("t3_spacing", cyc, (k == 0) ? 3 : 4);
            chk("t3_pen_cycles", pen, 1);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge PCLK);

        // PREADY stuck low: timeout after TMO ACCESS cycles
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h40; PREADY = 1'b0;
        wait_done(40, which, cyc, pen);
        chk("t4_owner", which, 0);
        chk("t4_pen_cycles", pen, 16);
        chk("t4_latency", cyc, 18);
        chk("t4_err0", err0, 1'b1);
        chk("t4_rdata", rsp_rdata, 32'h0);
        req0 = 1'b0;
        @(negedge PCLK);
        chk("t4_idle_psel", PSELx, 1'b0);
        chk("t4_idle_done", done0, 1'b0);

        // Payload changes after grant are ignored
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h11223344; strb0 = 4'hF;
        PREADY = 1'b0;
        @(negedge PCLK);
        chk("t5_setup_paddr", PADDR, 32'h10);
        addr0 = 32'h20; wdata0 = 32'h55;
        @(negedge PCLK);
        chk("t5_access_paddr", PADDR, 32'h10);
        chk("t5_access_pwdata", PWDATA, 32'h11223344);
        PREADY = 1'b1;
        @(negedge PCLK);
        chk("t5_done0", done0, 1'b1);
        req0 = 1'b0;
        @(negedge PCLK);

        // Reset during ACCESS: requester 1 (owner) aborted, requester 0 wins afterwards
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h300;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h400; wdata1 = 32'h77; strb1 = 4'h1;
        PREADY = 1'b0; PRDATA = 32'h600DF00D;
        @(negedge PCLK);
        chk("t6_setup_paddr", PADDR, 32'h400);
        @(negedge PCLK);
        chk("t6_access_pen", PENABLE, 1'b1);
        #2 PRESETn = 1'b0;
        #1;
        chk("t6_async_psel", PSELx, 1'b0);
        chk("t6_async_pen", PENABLE, 1'b0);
        @(negedge PCLK);
        chk("t6_no_done1", done1, 1'b0);
        PRESETn = 1'b1; PREADY = 1'b1;
        @(negedge PCLK);
        chk("t6_regrant_paddr", PADDR, 32'h300);
        wait_done(8, which, cyc, pen);
        chk("t6_owner", which, 0);
        chk("t6_rdata", rsp_rdata, 32'h600DF00D);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge PCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
